ecc_point_add: RTL and testbench

//  Elliptic-curve point adder over GF(p), 6-bit operands, curve y^2 = x^3 + a*x + b (mod p).

---
 rtl/ecc_point_add.sv | 145 ++++++++++++++
 tb/tb_ecc_point_add.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_point_add.sv
// rtl/ecc_point_add.sv - elliptic-curve point adder over GF(p), one job at a time
// Sequences slope, inversion (Fermat) and result steps through one shared modular multiplier.
module ecc_point_add #(
  parameter int WIDTH   = 6,
  parameter int MAX_LAT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_Px,
  input  logic [WIDTH-1:0] in_Py,
  input  logic [WIDTH-1:0] in_Qx,
  input  logic [WIDTH-1:0] in_Qy,
  input  logic [WIDTH-1:0] in_prime,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_Rx,
  output logic [WIDTH-1:0] out_Ry
);

  localparam int IW = $clog2(WIDTH);

  // Worst case: NUMDEN + 2*WIDTH inversion cycles + SLOPE/RX/RY + DONE entry.
  if (MAX_LAT < 2 * WIDTH + 6) begin : g_lat_chk
    $error("MAX_LAT too small for the inversion schedule");
  end

  typedef enum logic [2:0] {IDLE, NUMDEN, INV, SLOPE, RX, RY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
  logic [WIDTH-1:0] p_q, p_d, a_q, a_d;
  logic [WIDTH-1:0] num_q, num_d, den_q, den_d, acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d, rx_q, rx_d, ry_q, ry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             mph_q, mph_d;

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, y, m);
    logic [WIDTH:0] t;
    if (x >= y) t = {1'b0, x} - {1'b0, y};
    else        t = {1'b0, x} + {1'b0, m} - {1'b0, y};
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, y, m);
    logic [WIDTH:0] t;
    t = {1'b0, x} + {1'b0, y};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0]   mul_x, mul_y, mul_r, exp_bits, rdiff, dbl_num;
  logic [2*WIDTH-1:0] mul_prod, mod_div;
  logic [2*WIDTH+1:0] dbl_sum;

  assign exp_bits = p_q - WIDTH'(2);
  assign rdiff    = mod_sub(px_q, rx_q, p_q);
  // Idle p_q is 0; keep the reduction well defined without affecting live jobs.
  assign mod_div  = (p_q == '0) ? (2*WIDTH)'(1) : {{WIDTH{1'b0}}, p_q};
  assign mul_prod = {{WIDTH{1'b0}}, mul_x} * {{WIDTH{1'b0}}, mul_y};
  assign mul_r    = WIDTH'(mul_prod % mod_div);
  assign dbl_sum  = (2*WIDTH+2)'(3) * {2'b00, mul_prod} + {{(WIDTH+2){1'b0}}, a_q};
  assign dbl_num  = WIDTH'(dbl_sum % {2'b00, mod_div});

  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      NUMDEN: begin mul_x = px_q;  mul_y = px_q; end
      INV:    begin mul_x = acc_q; mul_y = mph_q ? den_q : acc_q; end
      SLOPE:  begin mul_x = num_q; mul_y = acc_q; end
      RX:     begin mul_x = s_q;   mul_y = s_q; end
      RY:     begin mul_x = s_q;   mul_y = rdiff; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    px_d = px_q; py_d = py_q; qx_d = qx_q; qy_d = qy_q; p_d = p_q; a_d = a_q;
    num_d = num_q; den_d = den_q; acc_d = acc_q; s_d = s_q;
    rx_d = rx_q; ry_d = ry_q; idx_d = idx_q; mph_d = mph_q;
    case (state_q)
      IDLE: if (in_valid) begin
        px_d = in_Px; py_d = in_Py; qx_d = in_Qx; qy_d = in_Qy;
        p_d = in_prime; a_d = in_a;
        state_d = NUMDEN;
      end
      NUMDEN: begin
        if (px_q == qx_q && py_q == qy_q) begin
          num_d = dbl_num;
          den_d = mod_add(py_q, py_q, p_q);
        end else begin
          num_d = mod_sub(qy_q, py_q, p_q);
          den_d = mod_sub(qx_q, px_q, p_q);
        end
        if (den_d == '0) begin
          rx_d = '0; ry_d = '0;
          state_d = DONE;
        end else begin
          acc_d = WIDTH'(1); idx_d = IW'(WIDTH - 1); mph_d = 1'b0;
          state_d = INV;
        end
      end
      // MSB-first over p-2: square every bit, then multiply by den where the bit is set.
      INV: begin
        acc_d = mul_r;
        if (!mph_q && exp_bits[idx_q]) begin
          mph_d = 1'b1;
        end else begin
          mph_d = 1'b0;
          if (idx_q == '0) state_d = SLOPE;
          else             idx_d = idx_q - IW'(1);
        end
      end
      SLOPE: begin s_d = mul_r; state_d = RX; end
      RX: begin
        rx_d = mod_sub(mod_sub(mul_r, px_q, p_q), qx_q, p_q);
        state_d = RY;
      end
      RY: begin ry_d = mod_sub(mul_r, py_q, p_q); state_d = DONE; end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      px_q <= '0; py_q <= '0; qx_q <= '0; qy_q <= '0; p_q <= '0; a_q <= '0;
      num_q <= '0; den_q <= '0; acc_q <= '0; s_q <= '0;
      rx_q <= '0; ry_q <= '0; idx_q <= '0; mph_q <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q <= px_d; py_q <= py_d; qx_q <= qx_d; qy_q <= qy_d; p_q <= p_d; a_q <= a_d;
      num_q <= num_d; den_q <= den_d; acc_q <= acc_d; s_q <= s_d;
      rx_q <= rx_d; ry_q <= ry_d; idx_q <= idx_d; mph_q <= mph_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_Rx    = out_valid ? rx_q : '0;
  assign out_Ry    = out_valid ? ry_q : '0;

endmodule

// File: tb/tb_ecc_point_add.sv
// tb/tb_ecc_point_add.sv - scoreboard bench for ecc_point_add
// Expected points come from spec constants or an independent brute-force-inverse model.
module tb_ecc_point_add;
  localparam int WIDTH = 6;
  localparam int MAX_LAT = 40;

  logic clk = 1'b0;
  logic rst, in_valid;
  logic [WIDTH-1:0] in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a;
  logic out_valid;
  logic [WIDTH-1:0] out_Rx, out_Ry;

  ecc_point_add #(.WIDTH(WIDTH), .MAX_LAT(MAX_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_Px(in_Px), .in_Py(in_Py), .in_Qx(in_Qx), .in_Qy(in_Qy),
    .in_prime(in_prime), .in_a(in_a),
    .out_valid(out_valid), .out_Rx(out_Rx), .out_Ry(out_Ry)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0, pulse_cnt = 0, idle_bad = 0;
  logic [2*WIDTH-1:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (out_valid) pulse_cnt <= pulse_cnt + 1;
    else if (out_Rx != '0 || out_Ry != '0) idle_bad <= idle_bad + 1;
  end

  function automatic int md(input int x, input int p);
    return ((x % p) + p) % p;
  endfunction

  function automatic logic [2*WIDTH-1:0] ref_add(input int px, py, qx, qy, p, a);
    int num, den, inv, s, rx, ry;
    if (px == qx && py == qy) begin
      num = md(3 * px * px + a, p); den = md(2 * py, p);
    end else begin
      num = md(qy - py, p); den = md(qx - px, p);
    end
    if (den == 0) return '0;
    inv = 0;
    for (int i = 1; i < p; i++) if ((den * i) % p == 1) inv = i;
    s  = md(num * inv, p);
    rx = md(s * s - px - qx, p);
    ry = md(s * (px - rx) - py, p);
    return {WIDTH'(rx), WIDTH'(ry)};
  endfunction

  task automatic drive(input int px, py, qx, qy, p, a, output int c0);
    in_valid = 1'b1;
    in_Px = WIDTH'(px); in_Py = WIDTH'(py); in_Qx = WIDTH'(qx); in_Qy = WIDTH'(qy);
    in_prime = WIDTH'(p); in_a = WIDTH'(a);
    c0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_Px = WIDTH'($urandom); in_Py = WIDTH'($urandom); in_Qx = WIDTH'($urandom);
    in_Qy = WIDTH'($urandom); in_prime = WIDTH'($urandom); in_a = WIDTH'($urandom);
  endtask

  task automatic wait_out(output bit ok, output logic [2*WIDTH-1:0] r, output int cs);
    ok = 1'b0; r = '0; cs = 0;
    for (int i = 0; i < MAX_LAT + 10 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; r = {out_Rx, out_Ry}; cs = cyc; end
    end
  endtask

  task automatic test_reset;
    int c0, cs, p0;
    bit ok;
    logic [2*WIDTH-1:0] r;
    checks++;
    if ({out_valid, out_Rx, out_Ry} !== '0) begin
      failures++; $display("FAIL reset_state got=%h want=0", {out_valid, out_Rx, out_Ry});
    end
    @(negedge clk); rst = 1'b0;
    drive(5, 1, 5, 1, 17, 2, c0);
    repeat (4) @(negedge clk);
    rst = 1'b1; #1;
    checks++;
    if ({out_valid, out_Rx, out_Ry} !== '0) begin
      failures++; $display("FAIL reset_midjob got=%h want=0", {out_valid, out_Rx, out_Ry});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); p0 = pulse_cnt;
    repeat (MAX_LAT + 5) @(posedge clk);
    checks++;
    if (pulse_cnt !== p0) begin
      failures++; $display("FAIL reset_nopulse got=%0d want=%0d", pulse_cnt, p0);
    end
    @(negedge clk);
    drive(6, 3, 5, 1, 17, 2, c0);
    wait_out(ok, r, cs);
    #2 rst = 1'b1; #1;
    checks++;
    if ({ok, out_valid, out_Rx, out_Ry} !== {1'b1, {(2*WIDTH+1){1'b0}}}) begin
      failures++; $display("FAIL reset_in_done got=%h want=%h", {ok, out_valid, out_Rx, out_Ry},
                           {1'b1, {(2*WIDTH+1){1'b0}}});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_doubling;
    int c0, cs;
    bit ok;
    logic [2*WIDTH-1:0] r, e;
    @(negedge clk);
    sb.push_back({6'd6, 6'd3});
    drive(5, 1, 5, 1, 17, 2, c0);
    wait_out(ok, r, cs);
    e = sb.pop_front();
    checks++;
    if (!ok || r !== e) begin failures++; $display("FAIL dbl got=%h ok=%0d want=%h", r, ok, e); end
    checks++;
    if (cs - c0 - 1 > MAX_LAT) begin failures++; $display("FAIL dbl_lat got=%0d max=%0d", cs - c0 - 1, MAX_LAT); end
  endtask

  task automatic test_addition;
    int v[2][4] = '{'{5, 1, 6, 3}, '{6, 3, 5, 1}};
    int c0, cs;
    bit ok;
    logic [2*WIDTH-1:0] r, e;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sb.push_back({6'd10, 6'd6});
      drive(v[k][0], v[k][1], v[k][2], v[k][3], 17, 2, c0);
      wait_out(ok, r, cs);
      e = sb.pop_front();
      checks++;
      if (!ok || r !== e) begin failures++; $display("FAIL add%0d got=%h ok=%0d want=%h", k, r, ok, e); end
    end
  endtask

  task automatic test_infinity;
    int v[2][4] = '{'{5, 1, 5, 16}, '{3, 0, 3, 0}};
    int c0, cs, p0;
    bit ok;
    logic [2*WIDTH-1:0] r, e;
    @(posedge clk); p0 = pulse_cnt;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sb.push_back('0);
      drive(v[k][0], v[k][1], v[k][2], v[k][3], 17, 2, c0);
      wait_out(ok, r, cs);
      e = sb.pop_front();
      checks++;
      if (!ok || r !== e || cs - c0 - 1 > MAX_LAT) begin
        failures++; $display("FAIL inf%0d got=%h ok=%0d lat=%0d want=%h", k, r, ok, cs - c0 - 1, e);
      end
    end
    repeat (3) @(posedge clk);
    checks++;
    if (pulse_cnt - p0 !== 2) begin failures++; $display("FAIL inf_pulses got=%0d want=2", pulse_cnt - p0); end
  endtask

  task automatic test_back_to_back;
    int c0, cs, p0;
    bit ok;
    logic [2*WIDTH-1:0] r, e;
    @(posedge clk); p0 = pulse_cnt;
    @(negedge clk);
    sb.push_back({6'd10, 6'd6});
    drive(5, 1, 6, 3, 17, 2, c0);
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_Px = 6'd5; in_Py = 6'd1; in_Qx = 6'd5; in_Qy = 6'd1;
    in_prime = 6'd17; in_a = 6'd2;
    @(negedge clk); in_valid = 1'b0;
    wait_out(ok, r, cs);
    e = sb.pop_front();
    checks++;
    if (!ok || r !== e) begin failures++; $display("FAIL busy got=%h ok=%0d want=%h", r, ok, e); end
    @(negedge clk);
    sb.push_back({6'd6, 6'd3});
    drive(5, 1, 5, 1, 17, 2, c0);
    wait_out(ok, r, cs);
    e = sb.pop_front();
    checks++;
    if (!ok || r !== e) begin failures++; $display("FAIL b2b got=%h ok=%0d want=%h", r, ok, e); end
    repeat (MAX_LAT) @(posedge clk);
    checks++;
    if (pulse_cnt - p0 !== 2) begin failures++; $display("FAIL busy_pulses got=%0d want=2", pulse_cnt - p0); end
  endtask

  task automatic test_idle_outputs;
    int primes[4] = '{17, 13, 61, 7};
    int c0, cs, p0, b0, p, a, px, py, qx, qy;
    bit ok;
    logic [2*WIDTH-1:0] r, e;
    @(posedge clk); p0 = pulse_cnt; b0 = idle_bad;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      p = primes[$urandom_range(0, 3)];
      a = $urandom_range(0, p - 1);
      px = $urandom_range(0, p - 1); py = $urandom_range(0, p - 1);
      qx = $urandom_range(0, p - 1); qy = $urandom_range(0, p - 1);
      if ($urandom_range(0, 2) == 0) begin qx = px; qy = py; end
      sb.push_back(ref_add(px, py, qx, qy, p, a));
      drive(px, py, qx, qy, p, a, c0);
      wait_out(ok, r, cs);
      e = sb.pop_front();
      checks++;
      if (!ok || r !== e) begin
        failures++; $display("FAIL rnd%0d p=%0d got=%h ok=%0d want=%h", k, p, r, ok, e);
      end
      repeat ($urandom_range(2, 4)) @(negedge clk);
    end
    @(posedge clk);
    checks++;
    if (idle_bad - b0 !== 0 || pulse_cnt - p0 !== 8) begin
      failures++; $display("FAIL idle_zero bad=%0d pulses=%0d want bad=0 pulses=8", idle_bad - b0, pulse_cnt - p0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    in_Px = '0; in_Py = '0; in_Qx = '0; in_Qy = '0; in_prime = '0; in_a = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_doubling();
    test_addition();
    test_infinity();
    test_back_to_back();
    test_idle_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
